// File: rtl/neuron_pkg.sv
// Shared constants, FSM state type and saturation limits for the neuron MAC datapath.
package neuron_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FRAC_BITS = 8;
    localparam int unsigned ACC_W     = 40;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StBias,
        StOut
    } state_e;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/neuron_saturate.sv
// Combinational Q-format rescale: arithmetic shift, clip to DATA_W, optional ReLU.
// Define NEURON_RELU_EN to force negative results to zero (hidden-layer neuron).
module neuron_saturate
    import neuron_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic        [DATA_W-1:0] data_o,
    output logic                     sat_o
);

    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] max_ext;
    logic signed [ACC_W-1:0] min_ext;

    // Arithmetic shift rounds toward minus infinity.
    assign shifted = acc_i >>> FRAC_BITS;
    assign max_ext = {{(ACC_W-DATA_W){SAT_MAX[DATA_W-1]}}, SAT_MAX};
    assign min_ext = {{(ACC_W-DATA_W){SAT_MIN[DATA_W-1]}}, SAT_MIN};

    always_comb begin
        data_o = shifted[DATA_W-1:0];
        sat_o  = 1'b0;
        if (shifted > max_ext) begin
            data_o = SAT_MAX;
            sat_o  = 1'b1;
        end else if (shifted < min_ext) begin
            data_o = SAT_MIN;
            sat_o  = 1'b1;
        end
`ifdef NEURON_RELU_EN
        // Negative clipping disappears under ReLU, so only positive clips flag.
        if (data_o[DATA_W-1]) begin
            data_o = '0;
            sat_o  = 1'b0;
        end
`else
`endif
    end

endmodule

// File: rtl/neuron_mac_unit.sv
// Single-neuron MAC: streams 28 activations against a weight BRAM, adds bias and
// emits one saturated Q8.8 result per frame. ReLU is enabled by NEURON_RELU_EN.
module neuron_mac_unit #(
    parameter int unsigned N_INPUTS  = 28,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned ACC_W     = 40
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic              W_EN,
    output logic              W_WE,
    input  logic [DATA_W-1:0] W_DATA,
    input  logic [DATA_W-1:0] BIAS,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_SAT,
    output logic              OUT_VALID,
    input  logic              OUT_READY
);

    import neuron_pkg::state_e;
    import neuron_pkg::StIdle;
    import neuron_pkg::StRun;
    import neuron_pkg::StBias;
    import neuron_pkg::StOut;

    localparam int unsigned       PROD_W = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(N_INPUTS);

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         count_q, count_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic                      p_valid_q, p_valid_d;
    logic [DATA_W-1:0]         out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;
    logic                      out_valid_q, out_valid_d;

    logic                      in_hs;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   biased;
    logic [DATA_W-1:0]         sat_data;
    logic                      sat_flag;

    assign IN_READY  = (state_q == StRun) && (count_q < LAST);
    assign in_hs     = IN_VALID & IN_READY;
    assign W_ADDR    = count_q;
    assign W_EN      = 1'b1;
    assign W_WE      = 1'b0;
    assign OUT_DATA  = out_data_q;
    assign OUT_SAT   = out_sat_q;
    assign OUT_VALID = out_valid_q;

    // Bias is Q8.8 while the accumulator is Q16.16, hence the pre-shift.
    assign bias_ext = {{(ACC_W-DATA_W){BIAS[DATA_W-1]}}, BIAS};
    assign biased   = acc_q + (bias_ext <<< FRAC_BITS);

    neuron_saturate u_saturate (
        .acc_i  (biased),
        .data_o (sat_data),
        .sat_o  (sat_flag)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        p_valid_d   = in_hs;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;

        if (p_valid_q) begin
            acc_d = acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
        end
        if (in_hs) begin
            prod_d  = PROD_W'($signed(IN_DATA)) * PROD_W'($signed(W_DATA));
            count_d = count_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                acc_d   = '0;
                state_d = StRun;
            end
            // The final product is folded into acc on the same edge that leaves RUN.
            StRun: begin
                if (count_q == LAST) begin
                    state_d = StBias;
                end
            end
            StBias: begin
                out_data_d  = sat_data;
                out_sat_d   = sat_flag;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    count_d     = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            count_q     <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            p_valid_q   <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            p_valid_q   <= p_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Self-checking bench for neuron_mac_unit: directed frames plus randomized frames
// compared against an arithmetic dot-product reference model.
module tb_neuron_mac_unit;

    localparam int N = 28;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] IN_DATA;
    logic        IN_VALID;
    logic        IN_READY;
    logic [4:0]  W_ADDR;
    logic        W_EN;
    logic        W_WE;
    logic [15:0] W_DATA;
    logic [15:0] BIAS;
    logic [15:0] OUT_DATA;
    logic        OUT_SAT;
    logic        OUT_VALID;
    logic        OUT_READY;

    logic [15:0] w_mem [N];
    logic [15:0] act   [N];

    int errors = 0;
    int checks = 0;

    neuron_mac_unit dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .W_ADDR    (W_ADDR),
        .W_EN      (W_EN),
        .W_WE      (W_WE),
        .W_DATA    (W_DATA),
        .BIAS      (BIAS),
        .OUT_DATA  (OUT_DATA),
        .OUT_SAT   (OUT_SAT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
    );

    always #5 CLK = ~CLK;

    // Weight BRAM: samples the address on the falling edge.
    always @(negedge CLK) begin
        if (W_EN) W_DATA <= (int'(W_ADDR) < N) ? w_mem[W_ADDR] : 16'h0000;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    // Reference: exact dot product + bias, floor-divided by 256, clamped to 16 bits.
    task automatic model(output logic [15:0] d, output logic s);
        longint sum = 0;
        longint q;
        for (int i = 0; i < N; i++) begin
            sum += longint'($signed(act[i])) * longint'($signed(w_mem[i]));
        end
        sum += longint'($signed(BIAS)) * 256;
        q = sum / 256;
        if (sum < 0 && (sum % 256) != 0) q = q - 1;
        s = 1'b0;
        if (q > 32767) begin
            q = 32767;
            s = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            s = 1'b1;
        end
`ifdef NEURON_RELU_EN
        if (q < 0) begin
            q = 0;
            s = 1'b0;
        end
`endif
        d = 16'(q);
    endtask

    // Feeds up to n activations; mode 0 = back-to-back, 1 = every other cycle, 2 = random.
    task automatic feed(input string tag, input int n, input int mode, output int k);
        int  cyc = 0;
        int  addr_bad = 0;
        bit  tog = 1'b1;
        k = 0;
        while (k < n && cyc < 400) begin
            @(negedge CLK);
            cyc++;
            case (mode)
                0:       IN_VALID = 1'b1;
                1:       IN_VALID = tog;
                default: IN_VALID = 1'($urandom_range(0, 1));
            endcase
            tog = ~tog;
            IN_DATA = IN_VALID ? act[k] : 16'($urandom);
            if (IN_VALID && IN_READY) begin
                if (int'(W_ADDR) != k) addr_bad++;
                k++;
            end
        end
        check({tag, "/accepted"}, k, n);
        check({tag, "/w_addr_seq"}, addr_bad, 0);
        @(posedge CLK);
        #1;
    endtask

    task automatic run_frame(input string tag, input int mode, input int hold,
                             input logic [15:0] exp_d, input logic exp_s);
        int          k;
        int          lat = 0;
        int          leak = 0;
        int          hold_bad = 0;
        logic [15:0] first_d;
        logic        first_s;
        feed(tag, N, mode, k);
        // Keep offering data: nothing may be accepted until the result drains.
        IN_VALID = 1'b1;
        IN_DATA  = 16'h7FFF;
        do begin
            @(negedge CLK);
            lat++;
            if (IN_READY) leak++;
        end while (!OUT_VALID && lat < 50);
        check({tag, "/latency"}, lat, 3);
        check({tag, "/data"}, OUT_DATA, exp_d);
        check({tag, "/sat"}, OUT_SAT, exp_s);
        first_d = OUT_DATA;
        first_s = OUT_SAT;
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            if (!OUT_VALID || OUT_DATA !== first_d || OUT_SAT !== first_s || IN_READY)
                hold_bad++;
        end
        check({tag, "/in_ready_low"}, leak, 0);
        if (hold > 0) check({tag, "/hold_stable"}, hold_bad, 0);
        OUT_READY = 1'b1;
        IN_VALID  = 1'b0;
        @(negedge CLK);
        check({tag, "/valid_drop"}, OUT_VALID, 1'b0);
        OUT_READY = 1'b0;
    endtask

    initial begin
        logic [15:0] md;
        logic        ms;
        int          k;
        RST_N     = 1'b0;
        IN_VALID  = 1'b0;
        IN_DATA   = 16'h0000;
        BIAS      = 16'h0000;
        OUT_READY = 1'b0;
        for (int i = 0; i < N; i++) w_mem[i] = 16'h0000;

        repeat (2) @(negedge CLK);
        check("rst/in_ready", IN_READY, 1'b0);
        check("rst/out_valid", OUT_VALID, 1'b0);
        check("rst/out_data", OUT_DATA, 16'h0000);
        check("rst/out_sat", OUT_SAT, 1'b0);
        check("rst/w_addr", W_ADDR, 5'd0);
        check("rst/w_en", W_EN, 1'b1);
        check("rst/w_we", W_WE, 1'b0);
        RST_N = 1'b1;

        for (int i = 0; i < N; i++) begin w_mem[i] = 16'h0100; act[i] = 16'h0100; end
        run_frame("unity", 0, 5, 16'h1C00, 1'b0);

        for (int i = 0; i < N; i++) w_mem[i] = 16'hFF00;
`ifdef NEURON_RELU_EN
        run_frame("neg_one", 0, 1, 16'h0000, 1'b0);
`else
        run_frame("neg_one", 0, 1, 16'hE400, 1'b0);
`endif

        for (int i = 0; i < N; i++) begin w_mem[i] = 16'h7F00; act[i] = 16'h7F00; end
        run_frame("pos_clip", 0, 2, 16'h7FFF, 1'b1);

        for (int i = 0; i < N; i++) begin w_mem[i] = 16'h0000; act[i] = 16'($urandom); end
        BIAS = 16'h0280;
        run_frame("bias_only", 0, 0, 16'h0280, 1'b0);

        BIAS = 16'h0000;
        for (int i = 0; i < N; i++) begin w_mem[i] = 16'(i * 256); act[i] = 16'h0100; end
        run_frame("gapped_ramp", 1, 1, 16'h7FFF, 1'b1);

        // Abort a frame after 10 activations; the next frame must start clean.
        for (int i = 0; i < N; i++) begin w_mem[i] = 16'h0100; act[i] = 16'h4000; end
        feed("partial", 10, 0, k);
        #1;
        RST_N    = 1'b0;
        IN_VALID = 1'b0;
        #1;
        check("midrst/in_ready", IN_READY, 1'b0);
        check("midrst/w_addr", W_ADDR, 5'd0);
        check("midrst/out_valid", OUT_VALID, 1'b0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < N; i++) act[i] = 16'h0100;
        run_frame("after_rst", 0, 1, 16'h1C00, 1'b0);

        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < N; i++) begin
                if (f % 2 == 0) begin
                    w_mem[i] = 16'($signed($urandom_range(0, 1023)) - 512);
                    act[i]   = 16'($signed($urandom_range(0, 1023)) - 512);
                end else begin
                    w_mem[i] = 16'($urandom);
                    act[i]   = 16'($urandom);
                end
            end
            BIAS = (f % 2 == 0) ? 16'($signed($urandom_range(0, 4095)) - 2048) : 16'($urandom);
            model(md, ms);
            run_frame($sformatf("rand%0d", f), 2, $urandom_range(0, 3), md, ms);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
